// File: rtl/objpool_pkg.sv
// Shared types and constants for the object pool manager and its per-slot FSMs.
package objpool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } slot_state_t;

    localparam int unsigned PIX_W = 12;
    localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 12'h000;

    localparam int unsigned VX_MOD  = 7;
    localparam int unsigned VY_BASE = 6;
    localparam int unsigned VY_MOD  = 10;

    function automatic int unsigned count_ones(input logic [7:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/objpool_slot_fsm.sv
// One object slot: lifecycle FSM, random respawn delay, spawn-parameter latches
// and the local reset for that slot's motion instance.
module objpool_slot_fsm
    import objpool_pkg::*;
#(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned SPAWN_Y = 375,
    parameter int unsigned OBJ_W   = 100,
    parameter int unsigned DELAY_W = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                tick,
    input  logic                grant,
    input  logic                oob,
    input  logic                kill,
    input  logic [15:0]         rand_in,
    input  logic [8*ADDR_W-1:0] sprite_base,
    output logic                ready,
    output logic                in_load,
    output logic                active,
    output logic                slot_rstn,
    output logic [9:0]          initposx,
    output logic [9:0]          initposy,
    output logic [9:0]          initvx,
    output logic [9:0]          initvy,
    output logic [ADDR_W-1:0]   addr
);

    localparam int unsigned X_SPAN = H_RES - OBJ_W;

    slot_state_t        state, state_nx;
    logic [DELAY_W-1:0] delay_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = WAIT;
            WAIT:    if (grant) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (kill || oob) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == WAIT) && (delay_cnt == '0);
        in_load   = (state == LOAD);
        active    = (state == RUN);
        slot_rstn = (state == RUN);
    end

    // Delay is frozen while the game is paused so a resumed slot keeps its place.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            delay_cnt <= '0;
        end else if (state == IDLE && en) begin
            delay_cnt <= rand_in[DELAY_W-1:0] | DELAY_W'(1);
        end else if (state == WAIT && en && tick && delay_cnt != '0) begin
            delay_cnt <= delay_cnt - DELAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            initposx <= '0;
            initposy <= '0;
            initvx   <= '0;
            initvy   <= '0;
            addr     <= '0;
        end else if (state == LOAD) begin
            initposx <= 10'(32'(rand_in[9:0]) % X_SPAN);
            initposy <= 10'(SPAWN_Y);
            initvx   <= 10'(32'(rand_in[15:13]) % VX_MOD);
            initvy   <= 10'(VY_BASE + 32'(rand_in[9:6]) % VY_MOD);
            addr     <= sprite_base[32'(rand_in[12:10])*ADDR_W +: ADDR_W];
        end
    end

endmodule

// File: rtl/object_pool_manager.sv
// Schedules NUM_OBJ flying-object slots and merges their pixels by fixed priority.
// Optional kill counter output is enabled by defining OBJPOOL_KILL_COUNT_EN.
module object_pool_manager
    import objpool_pkg::*;
#(
    parameter int unsigned NUM_OBJ   = 4,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned SPAWN_Y   = 375,
    parameter int unsigned OBJ_W     = 100,
    parameter int unsigned DELAY_W   = 6,
    parameter int unsigned SPAWN_GAP = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [15:0]               rand_in,
    input  logic                      moveclk,
    input  logic [8*ADDR_W-1:0]       sprite_base,
    input  logic [NUM_OBJ-1:0]        oob,
    input  logic [NUM_OBJ-1:0]        kill,
    input  logic [NUM_OBJ*PIX_W-1:0]  pix_in,
    output logic [NUM_OBJ-1:0]        slot_rstn,
    output logic [NUM_OBJ*10-1:0]     initposx,
    output logic [NUM_OBJ*10-1:0]     initposy,
    output logic [NUM_OBJ*10-1:0]     initvx,
    output logic [NUM_OBJ*10-1:0]     initvy,
    output logic [NUM_OBJ*ADDR_W-1:0] addr,
    output logic [NUM_OBJ-1:0]        active,
    output logic [PIX_W-1:0]          vga_data
`ifdef OBJPOOL_KILL_COUNT_EN
    ,
    output logic [15:0]               kill_count
`endif
);

    localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 1);

    logic               mclk_q, tick;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_OBJ-1:0] ready, in_load, grant;
    logic               spawn_ok, granted;
    logic [PIX_W-1:0]   pix_sel;
    logic               pix_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mclk_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            mclk_q <= moveclk;
            tick   <= moveclk & ~mclk_q;
        end
    end

    // Reload happens during LOAD; arbitration is blocked for that clk so the gap still holds.
    always_ff @(posedge clk) begin
        if (!rstn)                     gap_cnt <= GAP_W'(SPAWN_GAP);
        else if (|in_load)             gap_cnt <= GAP_W'(SPAWN_GAP);
        else if (tick && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
    end

    always_comb begin
        grant    = '0;
        granted  = 1'b0;
        spawn_ok = en && (gap_cnt == '0) && !(|in_load);
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (spawn_ok && ready[i] && !granted) begin
                grant[i] = 1'b1;
                granted  = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
        objpool_slot_fsm #(
            .ADDR_W (ADDR_W),
            .H_RES  (H_RES),
            .SPAWN_Y(SPAWN_Y),
            .OBJ_W  (OBJ_W),
            .DELAY_W(DELAY_W)
        ) u_slot (
            .clk        (clk),
            .rstn       (rstn),
            .en         (en),
            .tick       (tick),
            .grant      (grant[g]),
            .oob        (oob[g]),
            .kill       (kill[g]),
            .rand_in    (rand_in),
            .sprite_base(sprite_base),
            .ready      (ready[g]),
            .in_load    (in_load[g]),
            .active     (active[g]),
            .slot_rstn  (slot_rstn[g]),
            .initposx   (initposx[g*10 +: 10]),
            .initposy   (initposy[g*10 +: 10]),
            .initvx     (initvx[g*10 +: 10]),
            .initvy     (initvy[g*10 +: 10]),
            .addr       (addr[g*ADDR_W +: ADDR_W])
        );
    end

    always_comb begin
        pix_sel = PIX_TRANSPARENT;
        pix_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (!pix_hit && active[i] && pix_in[i*PIX_W +: PIX_W] != PIX_TRANSPARENT) begin
                pix_sel = pix_in[i*PIX_W +: PIX_W];
                pix_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) vga_data <= '0;
        else       vga_data <= pix_sel;
    end

`ifdef OBJPOOL_KILL_COUNT_EN
    logic [16:0] kill_sum;

    always_comb begin
        kill_sum = 17'(kill_count) + 17'(count_ones(8'(kill & active)));
    end

    always_ff @(posedge clk) begin
        if (!rstn)            kill_count <= '0;
        else if (kill_sum[16]) kill_count <= '1;
        else                  kill_count <= kill_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_object_pool_manager.sv
// Self-checking bench for object_pool_manager: directed scenarios plus randomized
// traffic compared every cycle against a behavioural slot/gap/pixel model.
module tb_object_pool_manager;

    localparam int N   = 4;
    localparam int AW  = 18;
    localparam int GAP = 8;

    logic              clk = 1'b0;
    logic              rstn, en, moveclk;
    logic [15:0]       rand_in;
    logic [8*AW-1:0]   sprite_base;
    logic [N-1:0]      oob, kill;
    logic [N*12-1:0]   pix_in;
    logic [N-1:0]      slot_rstn, active;
    logic [N*10-1:0]   initposx, initposy, initvx, initvy;
    logic [N*AW-1:0]   addr;
    logic [11:0]       vga_data;
`ifdef OBJPOOL_KILL_COUNT_EN
    logic [15:0]       kill_count;
`endif

    object_pool_manager #(
        .NUM_OBJ  (N),
        .ADDR_W   (AW),
        .H_RES    (640),
        .SPAWN_Y  (375),
        .OBJ_W    (100),
        .DELAY_W  (6),
        .SPAWN_GAP(GAP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .rand_in    (rand_in),
        .moveclk    (moveclk),
        .sprite_base(sprite_base),
        .oob        (oob),
        .kill       (kill),
        .pix_in     (pix_in),
        .slot_rstn  (slot_rstn),
        .initposx   (initposx),
        .initposy   (initposy),
        .initvx     (initvx),
        .initvy     (initvy),
        .addr       (addr),
        .active     (active),
        .vga_data   (vga_data)
`ifdef OBJPOOL_KILL_COUNT_EN
        ,
        .kill_count (kill_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: each slot is idle, waiting (with countdown), loading or alive.
    bit m_alive[N], m_wait[N], m_load[N];
    int m_cd[N], m_px[N], m_py[N], m_vx[N], m_vy[N], m_ad[N];
    int m_gap, m_vga, m_kc;
    bit m_tick, m_mc;
    int spr[8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pixv(input int i);
        logic [11:0] p;
        p = pix_in[i*12 +: 12];
        return int'(p);
    endfunction

    task automatic model_step();
        bit any_load;
        int win, nv, kills;
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                m_alive[i] = 0; m_wait[i] = 0; m_load[i] = 0; m_cd[i] = 0;
                m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_ad[i] = 0;
            end
            m_gap = GAP; m_vga = 0; m_kc = 0; m_tick = 0; m_mc = 0;
            return;
        end
        any_load = 0; win = -1; nv = 0; kills = 0;
        for (int i = 0; i < N; i++) any_load |= m_load[i];
        for (int i = 0; i < N; i++)
            if (win < 0 && m_wait[i] && m_cd[i] == 0 && en && m_gap == 0 && !any_load) win = i;
        for (int i = 0; i < N; i++)
            if (nv == 0 && m_alive[i] && pixv(i) != 0) nv = pixv(i);
        for (int i = 0; i < N; i++) begin
            if (m_load[i]) begin
                m_load[i] = 0; m_alive[i] = 1;
                m_px[i] = (int'(rand_in) & 'h3FF) % 540;
                m_py[i] = 375;
                m_vx[i] = (int'(rand_in) >> 13) % 7;
                m_vy[i] = 6 + ((int'(rand_in) >> 6) & 15) % 10;
                m_ad[i] = spr[(int'(rand_in) >> 10) & 7];
            end else if (m_alive[i]) begin
                if (kill[i]) kills++;
                if (kill[i] || oob[i]) m_alive[i] = 0;
            end else if (m_wait[i]) begin
                if (i == win) begin
                    m_wait[i] = 0; m_load[i] = 1;
                end else if (en && m_tick && m_cd[i] > 0) begin
                    m_cd[i]--;
                end
            end else if (en) begin
                m_wait[i] = 1;
                m_cd[i] = (int'(rand_in) & 63) | 1;
            end
        end
        if (any_load) m_gap = GAP;
        else if (m_tick && m_gap > 0) m_gap--;
        m_tick = moveclk && !m_mc;
        m_mc = moveclk;
        m_vga = nv;
        m_kc = (m_kc + kills > 65535) ? 65535 : m_kc + kills;
    endtask

    task automatic compare_all();
        logic [127:0] e_act, e_px, e_py, e_vx, e_vy, e_ad;
        e_act = '0; e_px = '0; e_py = '0; e_vx = '0; e_vy = '0; e_ad = '0;
        for (int i = 0; i < N; i++) begin
            e_act |= 128'(m_alive[i]) << i;
            e_px  |= 128'(m_px[i]) << (i*10);
            e_py  |= 128'(m_py[i]) << (i*10);
            e_vx  |= 128'(m_vx[i]) << (i*10);
            e_vy  |= 128'(m_vy[i]) << (i*10);
            e_ad  |= 128'(m_ad[i]) << (i*AW);
        end
        check("active", 128'(active), e_act);
        check("slot_rstn", 128'(slot_rstn), e_act);
        check("initposx", 128'(initposx), e_px);
        check("initposy", 128'(initposy), e_py);
        check("initvx", 128'(initvx), e_vx);
        check("initvy", 128'(initvy), e_vy);
        check("addr", 128'(addr), e_ad);
        check("vga_data", 128'(vga_data), 128'(m_vga));
`ifdef OBJPOOL_KILL_COUNT_EN
        check("kill_count", 128'(kill_count), 128'(m_kc));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int rises, rises_mark, c, n;
        bit done;
        logic [N-1:0] act0;

        for (int k = 0; k < 8; k++) spr[k] = k * 1000 + 7;
        for (int k = 0; k < 8; k++) sprite_base[k*AW +: AW] = AW'(spr[k]);
        rstn = 0; en = 0; moveclk = 0; rand_in = 0; oob = '0; kill = '0; pix_in = '0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) step();
        check("rst_active", 128'(active), 128'(0));
        check("rst_slot_rstn", 128'(slot_rstn), 128'(0));
        check("rst_vga", 128'(vga_data), 128'(0));
        check("rst_addr", 128'(addr), 128'(0));

        // First spawn: delay 5, gap 8, ticks every 4 clk.
        rstn = 1; en = 1; rand_in = 16'h0005;
        rises = 0; done = 0;
        for (c = 0; c < 200 && !done; c++) begin
            moveclk = (c % 4) < 2;
            if (c % 4 == 0) rises++;
            step();
            if (active[0]) done = 1;
        end
        check("p1_spawn_seen", 128'(done), 128'(1));
        check("p1_ticks_before_spawn", 128'(rises), 128'(8));
        check("p1_active_only0", 128'(active), 128'(4'b0001));
        check("p1_posx", 128'(initposx[9:0]), 128'(5));
        check("p1_posy", 128'(initposy[9:0]), 128'(375));
        check("p1_vx", 128'(initvx[9:0]), 128'(0));
        check("p1_vy", 128'(initvy[9:0]), 128'(6));
        check("p1_addr", 128'(addr[AW-1:0]), 128'(7));

        // All others were ready at the same time; slot 1 must wait a full gap.
        rises_mark = rises; done = 0;
        for (n = 0; n < 200 && !done; n++, c++) begin
            moveclk = (c % 4) < 2;
            if (c % 4 == 0) rises++;
            step();
            if (active[1]) done = 1;
        end
        check("p2_spawn1_seen", 128'(done), 128'(1));
        check("p2_ticks_gap", 128'(rises - rises_mark), 128'(8));
        check("p2_active", 128'(active), 128'(4'b0011));

        done = 0;
        for (n = 0; n < 300 && !done; n++, c++) begin
            moveclk = (c % 4) < 2;
            step();
            if (active[2]) done = 1;
        end
        check("p3_spawn2_seen", 128'(done), 128'(1));

        // Pixel merge priority.
        pix_in = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
        moveclk = 0;
        step();
        check("p3_merge_all", 128'(vga_data), 128'(12'hF00));
        oob = 4'b0010;
        step();
        oob = '0;
        step();
        check("p3_merge_no1", 128'(vga_data), 128'(12'h0F0));

        // Simultaneous kill and oob on slot 2.
        kill = 4'b0100; oob = 4'b0100;
        step();
        kill = '0; oob = '0;
        check("p4_active2_drop", 128'(active[2]), 128'(0));
`ifdef OBJPOOL_KILL_COUNT_EN
        check("p4_kill_count", 128'(kill_count), 128'(1));
`endif
        pix_in = '0;

        // Paused game: nothing new spawns, running slot 0 can still exit.
        en = 0;
        step(); step();
        act0 = active;
        for (n = 0; n < 60; n++, c++) begin
            moveclk = (c % 4) < 2;
            if (n == 10) oob = 4'b0001;
            step();
            oob = '0;
            if (n == 10) act0[0] = 1'b0;
            check("p5_no_spawn", 128'(active & ~act0), 128'(0));
        end
        check("p5_slot0_idle", 128'(active[0]), 128'(0));

        // Reset while several slots are running.
        en = 1; done = 0;
        for (n = 0; n < 800 && !done; n++, c++) begin
            moveclk = (c % 4) < 2;
            rand_in = 16'($urandom);
            pix_in = 48'({$urandom, $urandom});
            step();
            if ($countones(active) >= 3) done = 1;
        end
        check("p6_three_running", 128'(done), 128'(1));
        rstn = 0;
        step();
        check("p6_rst_active", 128'(active), 128'(0));
        check("p6_rst_vga", 128'(vga_data), 128'(0));
        check("p6_rst_slot_rstn", 128'(slot_rstn), 128'(0));
        rstn = 1;

        // Randomized traffic against the model.
        for (n = 0; n < 4000; n++) begin
            rstn    = ($urandom_range(0, 499) != 0);
            en      = ($urandom_range(0, 9) != 0);
            rand_in = 16'($urandom);
            if ($urandom_range(0, 1) == 1) moveclk = ~moveclk;
            for (int i = 0; i < N; i++) begin
                oob[i]  = ($urandom_range(0, 39) == 0);
                kill[i] = ($urandom_range(0, 39) == 0);
                pix_in[i*12 +: 12] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
